// File: rtl/project_mux.sv
// Wishbone project multiplexer: local CTRL/STATUS window, forwarding to one selected project, muxed GPIO.
// Optional build macro PROJECT_MUX_TIMEOUT_EN adds a forwarded-cycle timeout and the STATUS error flag.
module project_mux #(
    parameter int NUM_PROJECTS = 16,
    parameter int IO_W         = 38,
    parameter int TIMEOUT      = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [31:0]                  wbs_adr_i,
    input  logic [31:0]                  wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic [31:0]                  wbs_dat_o,
    output logic [NUM_PROJECTS-1:0]      proj_stb_o,
    input  logic [NUM_PROJECTS-1:0]      proj_ack_i,
    input  logic [32*NUM_PROJECTS-1:0]   proj_dat_i,
    output logic [NUM_PROJECTS-1:0]      active_o,
    input  logic [IO_W*NUM_PROJECTS-1:0] proj_io_out_i,
    input  logic [IO_W*NUM_PROJECTS-1:0] proj_io_oeb_i,
    output logic [IO_W-1:0]              io_out,
    output logic [IO_W-1:0]              io_oeb
);

    localparam int SW = $clog2(NUM_PROJECTS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCAL = 2'd1;
    localparam logic [1:0] FWD   = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

    if (NUM_PROJECTS < 2 || NUM_PROJECTS > 32) begin : g_bad_num_projects
        $error("project_mux: NUM_PROJECTS must be 2..32");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("project_mux: TIMEOUT must be 1..65535");
    end

    logic [1:0]              state;
    logic [SW-1:0]           sel;
    logic                    en;
    logic                    req;
    logic                    in_win;
    logic                    sel_ok;
    logic                    sel_ack;
    logic [NUM_PROJECTS-1:0] sel_onehot;
    logic [31:0]             slot_dat;
    logic [31:0]             status_word;
    logic [31:0]             local_rdata;
    logic [IO_W-1:0]         slot_io_out;
    logic [IO_W-1:0]         slot_io_oeb;
    logic [SW-1:0]           io_sel;
    logic                    io_en;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign in_win     = (wbs_adr_i[31:8] == 24'h30_0000);
    // The whole 31-bit SEL field is range-checked so out-of-range values are not silently truncated.
    assign sel_ok     = ({1'b0, wbs_dat_i[30:0]} < 32'(NUM_PROJECTS));
    assign sel_onehot = NUM_PROJECTS'(1) << sel;
    assign sel_ack    = proj_ack_i[sel];
    assign slot_dat   = proj_dat_i[32*sel +: 32];
    assign slot_io_out = proj_io_out_i[IO_W*sel +: IO_W];
    assign slot_io_oeb = proj_io_oeb_i[IO_W*sel +: IO_W];

`ifdef PROJECT_MUX_TIMEOUT_EN
    logic [15:0] wait_cnt;
    logic        timeout_err;
    logic [4:0]  last_sel;
    logic        timed_out;

    assign timed_out   = (wait_cnt == 16'(TIMEOUT - 1));
    assign status_word = {19'd0, last_sel, 7'd0, timeout_err};
`else
    assign status_word = 32'd0;
`endif

    always_comb begin
        local_rdata = 32'd0;
        case (wbs_adr_i[7:0])
            8'h00:   local_rdata = {en, 31'(sel)};
            8'h04:   local_rdata = status_word;
            default: local_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            sel        <= '0;
            en         <= 1'b0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'd0;
            proj_stb_o <= '0;
`ifdef PROJECT_MUX_TIMEOUT_EN
            wait_cnt    <= 16'd0;
            timeout_err <= 1'b0;
            last_sel    <= 5'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    wbs_ack_o <= 1'b0;
                    if (req) begin
                        if (in_win) begin
                            state     <= LOCAL;
                            wbs_ack_o <= 1'b1;
                            if (wbs_we_i) begin
                                if (wbs_adr_i[7:0] == 8'h00) begin
                                    if (wbs_sel_i[3]) en <= wbs_dat_i[31];
                                    if ((|wbs_sel_i) && sel_ok) sel <= wbs_dat_i[SW-1:0];
                                end
`ifdef PROJECT_MUX_TIMEOUT_EN
                                if (wbs_adr_i[7:0] == 8'h04 && wbs_sel_i[0] && wbs_dat_i[0])
                                    timeout_err <= 1'b0;
`endif
                            end else begin
                                wbs_dat_o <= local_rdata;
                            end
                        end else if (en) begin
                            state      <= FWD;
                            proj_stb_o <= sel_onehot;
`ifdef PROJECT_MUX_TIMEOUT_EN
                            wait_cnt <= 16'd0;
`endif
                        end else begin
                            // No project enabled: answer immediately rather than hang the master.
                            state     <= LOCAL;
                            wbs_ack_o <= 1'b1;
                            wbs_dat_o <= BAD_DATA;
                        end
                    end
                end
                LOCAL: begin
                    wbs_ack_o <= 1'b0;
                    state     <= RESP;
                end
                FWD: begin
                    if (!wbs_cyc_i) begin
                        proj_stb_o <= '0;
                        state      <= IDLE;
                    end else if (sel_ack) begin
                        wbs_dat_o  <= slot_dat;
                        wbs_ack_o  <= 1'b1;
                        proj_stb_o <= '0;
                        state      <= RESP;
                    end
`ifdef PROJECT_MUX_TIMEOUT_EN
                    else if (timed_out) begin
                        wbs_dat_o   <= BAD_DATA;
                        wbs_ack_o   <= 1'b1;
                        proj_stb_o  <= '0;
                        timeout_err <= 1'b1;
                        last_sel    <= 5'(sel);
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                RESP: begin
                    wbs_ack_o <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    wbs_ack_o  <= 1'b0;
                    proj_stb_o <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // GPIO path: any SEL/EN change first parks the pads (oeb high) for one cycle before the new slot drives.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            io_sel   <= '0;
            io_en    <= 1'b0;
            io_out   <= '0;
            io_oeb   <= '1;
            active_o <= '0;
        end else begin
            active_o <= en ? sel_onehot : '0;
            io_sel   <= sel;
            io_en    <= en;
            if ((sel != io_sel) || (en != io_en) || !en) begin
                io_out <= '0;
                io_oeb <= '1;
            end else begin
                io_out <= slot_io_out;
                io_oeb <= slot_io_oeb;
            end
        end
    end

endmodule

// File: doc/project_mux.md
PROJECT_MUX -- requirements
Module: project_mux

Interface
REQ-001 The block SHALL have parameter NUM_PROJECTS, default 16, number of project slots (2..32).
REQ-002 The block SHALL have parameter IO_W, default 38, GPIO width per project.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, forwarded-cycle wait limit in clocks (1..65535).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed in REQ-005 to REQ-019.
REQ-005 wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-006 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-007 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls.
REQ-008 wbs_sel_i  in  4  byte selects; forwarded unchanged.
REQ-009 wbs_adr_i, wbs_dat_i  in  32 each  address / write data.
REQ-010 wbs_ack_o  out  1  registered acknowledge.
REQ-011 wbs_dat_o  out  32  registered read data.
REQ-012 proj_stb_o  out  NUM_PROJECTS  per-project strobe, one-hot or zero.
REQ-013 proj_ack_i  in  NUM_PROJECTS  per-project acknowledge.
REQ-014 proj_dat_i  in  32*NUM_PROJECTS  packed per-project read data; slot k at [32k+31:32k].
REQ-015 active_o  out  NUM_PROJECTS  one-hot project enable, zero when disabled.
REQ-016 proj_io_out_i  in  IO_W*NUM_PROJECTS  packed per-project GPIO outputs.
REQ-017 proj_io_oeb_i  in  IO_W*NUM_PROJECTS  packed per-project GPIO output-enable-bar.
REQ-018 io_out  out  IO_W  registered muxed GPIO output.
REQ-019 io_oeb  out  IO_W  registered muxed GPIO oeb.

Function
REQ-020 Control window addresses 0x3000_0000..0x3000_00FF SHALL be local; all other addresses SHALL be forwarded.
REQ-021 CTRL at 0x3000_0000 SHALL hold SEL in bits [clog2(NUM_PROJECTS)-1:0] and EN in bit 31; other bits SHALL read 0.
REQ-022 STATUS at 0x3000_0004 SHALL hold a sticky TIMEOUT_ERR flag in bit 0, cleared by writing 1, and the last-timed-out SEL in bits [12:8].
REQ-023 Reads of unmapped control-window addresses SHALL return 0; writes to them SHALL be ignored.
REQ-024 A SEL write value >= NUM_PROJECTS SHALL be ignored, leaving SEL unchanged.
REQ-025 The FSM SHALL have states IDLE, LOCAL, FWD and RESP.
REQ-026 IDLE with cyc&stb in the control window SHALL go to LOCAL; wbs_ack_o SHALL be 1 the next cycle, with the write applied or read data on wbs_dat_o; then RESP.
REQ-027 IDLE with cyc&stb outside the window and EN=1 SHALL go to FWD and assert proj_stb_o[SEL] from the next cycle.
REQ-028 In FWD, proj_ack_i[SEL]=1 SHALL latch proj_dat_i slot SEL into wbs_dat_o, pulse wbs_ack_o for exactly one cycle, clear proj_stb_o, and go to RESP.
REQ-029 A forwarded access with EN=0 SHALL ack after 1 cycle with wbs_dat_o=0xDEADBEEF and SHALL NOT strobe any project.
REQ-030 RESP SHALL return to IDLE after one cycle; a new request SHALL NOT be accepted in RESP.
REQ-031 wbs_cyc_i falling in FWD SHALL abort: proj_stb_o cleared next cycle, no ack, state IDLE.
REQ-032 proj_ack_i of non-selected slots SHALL be ignored.
REQ-033 active_o SHALL equal one-hot(SEL) when EN=1, else 0, registered.
REQ-034 io_out/io_oeb SHALL be registered copies of slot SEL when EN=1; when EN=0, io_out=0 and io_oeb=all ones.
REQ-035 On any change of SEL or EN, io_oeb SHALL be all ones and io_out 0 for exactly one cycle (break-before-make) before the new slot drives.

Reset
REQ-036 wb_rst_i=1 at a clock edge SHALL force IDLE, SEL=0, EN=0, TIMEOUT_ERR=0, wbs_ack_o=0, wbs_dat_o=0, proj_stb_o=0, active_o=0, io_out=0, io_oeb=all ones.
REQ-037 Reset mid-transaction SHALL abort without ack, and the first request after reset deasserts SHALL be handled normally.

Configuration
REQ-038 With macro PROJECT_MUX_TIMEOUT_EN defined, FWD SHALL count cycles; after TIMEOUT cycles without proj_ack_i[SEL] it SHALL ack with 0xDEADBEEF, drop proj_stb_o, set TIMEOUT_ERR, record SEL, and go to RESP.
REQ-039 Without PROJECT_MUX_TIMEOUT_EN, FWD SHALL wait indefinitely, no counter SHALL exist, and STATUS SHALL read 0.

Verification
REQ-040 Write CTRL=0x8000_0003, then read CTRL -> ack 1 cycle after stb; read data 0x8000_0003; active_o=0x0008; io_oeb all ones for one cycle, then slot 3 values.
REQ-041 EN=1, SEL=3, read 0x3000_1000 with slot 3 acking 2 cycles late with data 0x1234_5678 -> proj_stb_o=0x0008; wbs_dat_o=0x1234_5678; single-cycle ack.
REQ-042 EN=0, read 0x3000_1000 -> ack with 0xDEADBEEF; proj_stb_o stays 0.
REQ-043 With PROJECT_MUX_TIMEOUT_EN and TIMEOUT=8, slot 5 never acks -> ack after 8 FWD cycles with 0xDEADBEEF; STATUS reads 0x0000_0501; writing 1 to STATUS clears it to 0x0000_0500.
REQ-044 Assert wb_rst_i during FWD, then write CTRL=0x8000_0040 with NUM_PROJECTS=16 -> all outputs at reset values; SEL stays 0 (write ignored); EN=1.
